// File: rtl/dm_resp.sv
// ---------------------------------------------------------------------------
// dm_resp
//
// Purpose:
//    Single-outstanding data-memory responder. A request (load, store, both
//    or neither) is accepted in IDLE, held for WAIT_CYCLES extra cycles and
//    completed with a one-cycle rsp_valid pulse. Loads read the word as it
//    was before any store of the same request; the store is committed on
//    the edge that leaves RESP. Out-of-range requests answer rsp_err=1,
//    rdata=0 and never touch the storage array.
//
// Optional feature:
//    DM_LOAD_ALIGN_EN  when defined, loads are shifted by the byte offset
//                      and sign/zero extended according to the load code.
//                      When undefined, every load returns the raw word.
//
// Parameters:
//    DEPTH_WORDS  number of 32-bit words (power of 2, >= 4)
//    WAIT_CYCLES  extra cycles between acceptance and response (0..7)
//
// Ports:
//    clk        in   clock, rising edge
//    rst        in   asynchronous active-high reset
//    req_valid  in   request present
//    req_ready  out  responder idle and able to accept
//    addr       in   byte address
//    is_load    in   001 LW, 010 LH, 011 LB, 100 LHU, 101 LBU, else no load
//    bweb       in   active-low bit write mask (all ones = no store)
//    wdata      in   store data, already lane-shifted
//    rsp_valid  out  one-cycle completion pulse
//    rdata      out  load result, meaningful while rsp_valid is 1
//    rsp_err    out  out-of-range flag, meaningful while rsp_valid is 1
// ---------------------------------------------------------------------------
module dm_resp #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] addr,
   input  logic [2:0]  is_load,
   input  logic [31:0] bweb,
   input  logic [31:0] wdata,
   output logic        rsp_valid,
   output logic [31:0] rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   // Counter preload for the WAIT state; irrelevant when WAIT_CYCLES is 0
   // because WAIT is then never entered.
   localparam int CNT_INIT_INT = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
   localparam logic [2:0] CNT_INIT = 3'(CNT_INIT_INT);

`ifdef DM_LOAD_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t         state_q;
   logic [2:0]     cnt_q;
   logic [AW-1:0]  idx_q;
   logic [2:0]     ld_q;
   logic [1:0]     off_q;
   logic [31:0]    bweb_q;
   logic [31:0]    wdata_q;
   logic           oor_q;
   logic           req_ready_q;
   logic           rsp_valid_q;
   logic [31:0]    rdata_q;
   logic           rsp_err_q;

   // Storage array; deliberately not reset.
   logic [31:0]    mem [DEPTH_WORDS];

   logic           inIdle;
   logic [AW-1:0]  readIdx;
   logic [2:0]     readLd;
   logic [1:0]     readOff;
   logic           readOor;
   logic           addrOor;
   logic [31:0]    memWord;
   logic [31:0]    shifted;
   logic [31:0]    loadData_d;
   logic [31:0]    respData_d;
   logic [31:0]    memWrite_d;
   logic           wrEn;

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rdata     = rdata_q;
   assign rsp_err   = rsp_err_q;

   // Any set bit above the word-index field places the address beyond the
   // array, i.e. addr[31:2] >= DEPTH_WORDS.
   assign addrOor = |addr[31:AW+2];

   // With WAIT_CYCLES=0 the response is formed on the acceptance edge
   // itself, before the latches hold the request, so in IDLE the read side
   // looks straight at the inputs. In every other state it uses the latched
   // copy, which keeps later input changes from leaking in.
   assign inIdle  = (state_q == IDLE);
   assign readIdx = inIdle ? addr[AW+1:2] : idx_q;
   assign readLd  = inIdle ? is_load      : ld_q;
   assign readOff = inIdle ? addr[1:0]    : off_q;
   assign readOor = inIdle ? addrOor      : oor_q;

   assign memWord = mem[readIdx];

   // When alignment is disabled the shift amount is forced to zero, so the
   // extension cases below collapse onto the raw word.
   assign shifted = memWord >> (ALIGN_EN ? {readOff, 3'b000} : 5'd0);

   // Load formatting by load code; unknown codes mean "no load".
   always_comb begin
      loadData_d = 32'd0;
      case (readLd)
         3'b001: loadData_d = shifted;
         3'b010: loadData_d = ALIGN_EN ? {{16{shifted[15]}}, shifted[15:0]} : shifted;
         3'b011: loadData_d = ALIGN_EN ? {{24{shifted[7]}},  shifted[7:0]}  : shifted;
         3'b100: loadData_d = ALIGN_EN ? {16'd0, shifted[15:0]}             : shifted;
         3'b101: loadData_d = ALIGN_EN ? {24'd0, shifted[7:0]}              : shifted;
         default: loadData_d = 32'd0;
      endcase
   end

   assign respData_d = readOor ? 32'd0 : loadData_d;

   // In RESP readIdx equals idx_q, so memWord is the word being merged.
   // Mask bits at 0 take the new data, bits at 1 keep the old contents.
   assign memWrite_d = (memWord & bweb_q) | (wdata_q & ~bweb_q);
   assign wrEn       = (state_q == RESP) && !oor_q && (bweb_q != 32'hFFFF_FFFF);

   // Store commit on the edge that leaves RESP. The read for the response
   // was captured on the edge entering RESP, giving read-before-write. A
   // reset during the request forces IDLE, so the write is simply skipped.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[idx_q] <= memWrite_d;
      end
   end

   // Request FSM with registered handshake and response outputs. The
   // response data is computed on the edge that enters RESP and cleared on
   // the edge that leaves it, so rdata/rsp_err read as 0 outside the pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         idx_q       <= '0;
         ld_q        <= 3'd0;
         off_q       <= 2'd0;
         bweb_q      <= 32'hFFFF_FFFF;
         wdata_q     <= 32'd0;
         oor_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  idx_q       <= addr[AW+1:2];
                  ld_q        <= is_load;
                  off_q       <= addr[1:0];
                  bweb_q      <= bweb;
                  wdata_q     <= wdata;
                  oor_q       <= addrOor;
                  req_ready_q <= 1'b0;
                  if (WAIT_CYCLES > 0) begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end else begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rdata_q     <= respData_d;
                     rsp_err_q   <= readOor;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 3'd0) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rdata_q     <= respData_d;
                  rsp_err_q   <= readOor;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            RESP: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rdata_q     <= 32'd0;
               rsp_err_q   <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               cnt_q       <= 3'd0;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rdata_q     <= 32'd0;
               rsp_err_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_resp.sv
// ---------------------------------------------------------------------------
// tb_dm_resp
//
// Self-checking bench for dm_resp. One instance uses the default
// configuration (1024 words, one wait cycle); a second, small instance uses
// WAIT_CYCLES=0 for the back-to-back handshake sequence. Expected results
// come from a directed vector table and from a word-array reference model.
// ---------------------------------------------------------------------------
module tb_dm_resp;

`ifdef DM_LOAD_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        reqValid;
   logic        reqReady;
   logic [31:0] addr;
   logic [2:0]  isLoad;
   logic [31:0] bweb;
   logic [31:0] wdata;
   logic        rspValid;
   logic [31:0] rdata;
   logic        rspErr;

   logic        r0Valid;
   logic        r0Ready;
   logic [31:0] r0Addr;
   logic [2:0]  r0Ld;
   logic [31:0] r0Bweb;
   logic [31:0] r0Wdata;
   logic        r0Rsp;
   logic [31:0] r0Rdata;
   logic        r0Err;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   dm_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
      .clk(clock), .rst(reset),
      .req_valid(reqValid), .req_ready(reqReady),
      .addr(addr), .is_load(isLoad), .bweb(bweb), .wdata(wdata),
      .rsp_valid(rspValid), .rdata(rdata), .rsp_err(rspErr)
   );

   dm_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
      .clk(clock), .rst(reset),
      .req_valid(r0Valid), .req_ready(r0Ready),
      .addr(r0Addr), .is_load(r0Ld), .bweb(r0Bweb), .wdata(r0Wdata),
      .rsp_valid(r0Rsp), .rdata(r0Rdata), .rsp_err(r0Err)
   );

   // Watchdog so the run always ends.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Compare one value, count it, report a miss.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference load: word value viewed as a number, shifted by whole bytes
   // and reduced to the requested lane width.
   function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [2:0] code, input int off);
      longint v;
      longint lane;
      if (!ALIGN) return (code >= 3'd1 && code <= 3'd5) ? w : 32'd0;
      v = longint'(w) / (longint'(1) << (8 * off));
      case (code)
         3'd1: return 32'(v);
         3'd2: begin lane = v % 65536; if (lane >= 32768) lane -= 65536; return 32'(lane); end
         3'd3: begin lane = v % 256;   if (lane >= 128)   lane -= 256;   return 32'(lane); end
         3'd4: return 32'(v % 65536);
         3'd5: return 32'(v % 256);
         default: return 32'd0;
      endcase
   endfunction

   // Reference store: bit by bit, a mask bit of 0 selects the new data.
   function automatic logic [31:0] refStore(input logic [31:0] old, input logic [31:0] m, input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = m[i] ? old[i] : d[i];
      return r;
   endfunction

   // Issue one request on the main instance starting at a falling edge and
   // return the response plus its latency in cycles after the acceptance
   // edge. Inputs are scrambled right after acceptance.
   task automatic applyStimulus(input logic [31:0] a, input logic [2:0] l,
                                input logic [31:0] bw, input logic [31:0] wd,
                                output logic [31:0] d, output logic e, output int lat);
      int guard;
      addr = a; isLoad = l; bweb = bw; wdata = wd; reqValid = 1'b1;
      guard = 0;
      while (!reqReady && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      @(negedge clock);
      reqValid = 1'b0;
      addr = $urandom; isLoad = 3'($urandom); bweb = $urandom; wdata = $urandom;
      lat = 1;
      while (!rspValid && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      d = rdata;
      e = rspErr;
      @(negedge clock);
      checkOutput("pulseOnce", 32'(rspValid), 32'd0);
      checkOutput("errIdle",   32'(rspErr),   32'd0);
      checkOutput("readyBack", 32'(reqReady), 32'd1);
   endtask

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [2:0]  ld;
      logic [31:0] bw;
      logic [31:0] wd;
      logic [31:0] expData;
      logic        expErr;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   logic [31:0] model [16];

   initial begin
      logic [31:0] gotD;
      logic        gotE;
      int          lat;
      logic [31:0] expD0 [3];
      logic        expE0 [3];
      logic [31:0] addr0 [3];
      logic [2:0]  ld0   [3];
      logic [31:0] bw0   [3];
      logic [31:0] wd0   [3];
      int          pulses;

      vecs[0]  = '{"sw0",    32'h0000_0000, 3'b000, 32'h0000_0000, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
      vecs[1]  = '{"sw10",   32'h0000_0010, 3'b000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[2]  = '{"lw10",   32'h0000_0010, 3'b001, 32'hFFFF_FFFF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{"lb13",   32'h0000_0013, 3'b011, 32'hFFFF_FFFF, 32'h0000_0000, ALIGN ? 32'hFFFF_FFDE : 32'hDEAD_BEEF, 1'b0};
      vecs[4]  = '{"lbu13",  32'h0000_0013, 3'b101, 32'hFFFF_FFFF, 32'h0000_0000, ALIGN ? 32'h0000_00DE : 32'hDEAD_BEEF, 1'b0};
      vecs[5]  = '{"lh12",   32'h0000_0012, 3'b010, 32'hFFFF_FFFF, 32'h0000_0000, ALIGN ? 32'hFFFF_DEAD : 32'hDEAD_BEEF, 1'b0};
      vecs[6]  = '{"lhu10",  32'h0000_0010, 3'b100, 32'hFFFF_FFFF, 32'h0000_0000, ALIGN ? 32'h0000_BEEF : 32'hDEAD_BEEF, 1'b0};
      vecs[7]  = '{"lb11",   32'h0000_0011, 3'b011, 32'hFFFF_FFFF, 32'h0000_0000, ALIGN ? 32'hFFFF_FFBE : 32'hDEAD_BEEF, 1'b0};
      vecs[8]  = '{"sw20",   32'h0000_0020, 3'b000, 32'h0000_0000, 32'h1122_3344, 32'h0000_0000, 1'b0};
      vecs[9]  = '{"sb22",   32'h0000_0022, 3'b000, 32'hFF00_FFFF, 32'h00AA_0000, 32'h0000_0000, 1'b0};
      vecs[10] = '{"lw20",   32'h0000_0020, 3'b001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h11AA_3344, 1'b0};
      vecs[11] = '{"oor",    32'h0000_1000, 3'b001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      vecs[12] = '{"lw0",    32'h0000_0000, 3'b001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0BAD_F00D, 1'b0};
      vecs[13] = '{"noop",   32'h0000_0010, 3'b110, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[14] = '{"ldst",   32'h0000_0010, 3'b001, 32'h0000_0000, 32'h0123_4567, 32'hDEAD_BEEF, 1'b0};
      vecs[15] = '{"lw10b",  32'h0000_0010, 3'b001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0123_4567, 1'b0};

      reqValid = 1'b0; addr = '0; isLoad = '0; bweb = '1; wdata = '0;
      r0Valid = 1'b0; r0Addr = '0; r0Ld = '0; r0Bweb = '1; r0Wdata = '0;

      // Reset state.
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("reset.ready", 32'(reqReady), 32'd1);
      checkOutput("reset.rsp",   32'(rspValid), 32'd0);
      checkOutput("reset.rdata", rdata,         32'd0);
      checkOutput("reset.err",   32'(rspErr),   32'd0);
      checkOutput("reset.ready0", 32'(r0Ready), 32'd1);
      reset = 1'b0;
      @(negedge clock);

      // Directed table.
      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i].a, vecs[i].ld, vecs[i].bw, vecs[i].wd, gotD, gotE, lat);
         checkOutput({vecs[i].name, ".rdata"}, gotD, vecs[i].expData);
         checkOutput({vecs[i].name, ".err"},   32'(gotE), 32'(vecs[i].expErr));
         checkOutput({vecs[i].name, ".lat"},   32'(lat), 32'd2);
      end

      // Reset in the middle of a store: no response, no write.
      applyStimulus(32'h30, 3'b000, 32'h0, 32'h1234_5678, gotD, gotE, lat);
      addr = 32'h30; isLoad = 3'b000; bweb = 32'h0; wdata = 32'hFFFF_FFFF; reqValid = 1'b1;
      checkOutput("rst.readyPre", 32'(reqReady), 32'd1);
      @(negedge clock);
      reqValid = 1'b0;
      checkOutput("rst.inWait", 32'(reqReady), 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("rst.readyNow", 32'(reqReady), 32'd1);
      checkOutput("rst.rspNow",   32'(rspValid), 32'd0);
      repeat (2) begin
         @(negedge clock);
         checkOutput("rst.rspHeld", 32'(rspValid), 32'd0);
      end
      reset = 1'b0;
      checkOutput("rst.readyRel", 32'(reqReady), 32'd1);
      repeat (3) begin
         @(negedge clock);
         checkOutput("rst.rspAfter", 32'(rspValid), 32'd0);
      end
      applyStimulus(32'h30, 3'b001, 32'hFFFF_FFFF, 32'h0, gotD, gotE, lat);
      checkOutput("rst.word", gotD, 32'h1234_5678);

      // Randomized traffic over words 0..15 plus aliased out-of-range hits.
      for (int w = 0; w < 16; w++) begin
         model[w] = $urandom;
         applyStimulus(32'(w * 4), 3'b000, 32'h0, model[w], gotD, gotE, lat);
         checkOutput("init.err", 32'(gotE), 32'd0);
      end
      for (int n = 0; n < 60; n++) begin
         int          w;
         int          off;
         int          sel;
         logic [31:0] a;
         logic [2:0]  l;
         logic [31:0] bw;
         logic [31:0] wd;
         logic        expE;
         logic [31:0] expD;
         w   = $urandom_range(0, 15);
         off = $urandom_range(0, 3);
         sel = $urandom_range(0, 3);
         l   = 3'($urandom_range(0, 7));
         wd  = $urandom;
         a   = 32'(w * 4 + off);
         if ($urandom_range(0, 5) == 0) a = a + 32'h1000 * 32'($urandom_range(1, 4));
         case (sel)
            0: bw = 32'hFFFF_FFFF;
            1: bw = 32'h0000_0000;
            2: bw = $urandom;
            default: bw = ~(32'hFF << (8 * off));
         endcase
         expE = ((a >> 2) >= 32'd1024);
         expD = expE ? 32'd0 : refLoad(model[w], l, off);
         applyStimulus(a, l, bw, wd, gotD, gotE, lat);
         checkOutput($sformatf("rnd%0d.rdata", n), gotD, expD);
         checkOutput($sformatf("rnd%0d.err", n), 32'(gotE), 32'(expE));
         checkOutput($sformatf("rnd%0d.lat", n), 32'(lat), 32'd2);
         if (!expE && bw != 32'hFFFF_FFFF) model[w] = refStore(model[w], bw, wd);
      end
      for (int w = 0; w < 16; w++) begin
         applyStimulus(32'(w * 4), 3'b001, 32'hFFFF_FFFF, 32'h0, gotD, gotE, lat);
         checkOutput($sformatf("final.w%0d", w), gotD, model[w]);
      end

      // WAIT_CYCLES=0, req_valid held high for three requests.
      addr0[0] = 32'h04;  ld0[0] = 3'b000; bw0[0] = 32'h0;         wd0[0] = 32'hCAFE_F00D;
      expD0[0] = 32'h0;   expE0[0] = 1'b0;
      addr0[1] = 32'h04;  ld0[1] = 3'b001; bw0[1] = 32'hFFFF_FFFF; wd0[1] = 32'h0;
      expD0[1] = 32'hCAFE_F00D; expE0[1] = 1'b0;
      addr0[2] = 32'h100; ld0[2] = 3'b001; bw0[2] = 32'h0;         wd0[2] = 32'h0;
      expD0[2] = 32'h0;   expE0[2] = 1'b1;
      pulses = 0;
      r0Valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c % 2 == 0) begin
            r0Addr = addr0[c/2]; r0Ld = ld0[c/2]; r0Bweb = bw0[c/2]; r0Wdata = wd0[c/2];
         end else begin
            r0Addr = $urandom; r0Ld = 3'($urandom); r0Bweb = $urandom; r0Wdata = $urandom;
         end
         checkOutput($sformatf("wc0.ready%0d", c), 32'(r0Ready), 32'(c % 2 == 0));
         checkOutput($sformatf("wc0.rsp%0d", c),   32'(r0Rsp),   32'(c % 2 == 1));
         if (r0Rsp) begin
            pulses++;
            checkOutput($sformatf("wc0.rdata%0d", c/2), r0Rdata, expD0[c/2]);
            checkOutput($sformatf("wc0.err%0d", c/2),   32'(r0Err), 32'(expE0[c/2]));
         end
         @(negedge clock);
      end
      r0Valid = 1'b0;
      checkOutput("wc0.readyEnd", 32'(r0Ready), 32'd1);
      checkOutput("wc0.rspEnd",   32'(r0Rsp),   32'd0);
      @(negedge clock);
      checkOutput("wc0.readyIdle", 32'(r0Ready), 32'd1);
      checkOutput("wc0.rspIdle",   32'(r0Rsp),   32'd0);
      checkOutput("wc0.pulses", 32'(pulses), 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the storage array; a power of 2, at least 4.
REQ-002 Parameter WAIT_CYCLES, default 1, legal range 0..7: extra cycles between request acceptance and response.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present this cycle.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 addr  input  32  byte address.
REQ-008 is_load  input  3  load code: 001 LW, 010 LH, 011 LB, 100 LHU, 101 LBU; any other code means no load.
REQ-009 bweb  input  32  active-low bit write mask; all ones means no store.
REQ-010 wdata  input  32  store data, already lane-shifted by the requester.
REQ-011 rsp_valid  output  1  one-cycle pulse that completes a request.
REQ-012 rdata  output  32  load result, valid only while rsp_valid is 1.
REQ-013 rsp_err  output  1  out-of-range flag, valid only while rsp_valid is 1.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 in IDLE only; a request is accepted when req_valid and req_ready are both 1.
REQ-016 On acceptance the block SHALL latch addr, is_load, bweb and wdata. Later input changes SHALL be ignored until the next acceptance.
REQ-017 On acceptance, the next state SHALL be WAIT with the counter loaded to WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise the next state SHALL be RESP.
REQ-018 In WAIT the counter SHALL decrement each cycle; at count 0 the next state SHALL be RESP.
REQ-019 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be WAIT_CYCLES+1 cycles from the acceptance edge to the rsp_valid cycle.
REQ-021 Back-to-back throughput SHALL be one request per WAIT_CYCLES+2 cycles.
REQ-022 The word index SHALL be latched addr[log2(DEPTH_WORDS)+1:2].
REQ-023 An address is out of range when addr[31:2] >= DEPTH_WORDS.
REQ-024 An out-of-range request SHALL produce rsp_err=1 and rdata=0, and SHALL perform no write.
REQ-025 Store handling:
- the write SHALL happen on the edge that leaves RESP;
- each bit whose bweb bit is 0 SHALL take the wdata bit;
- each bit whose bweb bit is 1 SHALL be kept.
REQ-026 Read handling: rdata SHALL be derived from the word as it was before any write of the same request (read-before-write).
REQ-027 For a request with no load, rdata SHALL be 0.
REQ-028 A request with no load and no store SHALL still be acknowledged with one rsp_valid pulse.
REQ-029 rsp_err SHALL be 0 whenever rsp_valid is 0.
REQ-030 The storage array SHALL NOT be reset; its contents are undefined until written.

Reset
REQ-031 Asserting rst SHALL immediately force:
- FSM to IDLE and counter to 0;
- req_ready=1, rsp_valid=0, rdata=0, rsp_err=0.
REQ-032 A request in flight when rst asserts SHALL be dropped, with no write and no response.

Configuration
REQ-033 The macro DM_LOAD_ALIGN_EN SHALL control load alignment.
REQ-034 With DM_LOAD_ALIGN_EN defined:
- the word SHALL first be shifted right by 8*addr[1:0], zero-filling from the top;
- LB SHALL sign-extend bits [7:0];
- LBU SHALL zero-extend bits [7:0];
- LH SHALL sign-extend bits [15:0];
- LHU SHALL zero-extend bits [15:0];
- LW SHALL return the full shifted word.
REQ-035 Without DM_LOAD_ALIGN_EN: every load code SHALL return the raw stored word unshifted, and the requester performs alignment.

Verification
REQ-036 Reset: assert rst mid-WAIT -> rsp_valid stays 0, req_ready=1 on release, and the target word is unchanged.
REQ-037 SW then LW, WAIT_CYCLES=1: store to 0x10 with bweb=0x00000000 and wdata=0xDEADBEEF, then LW 0x10 -> rdata=0xDEADBEEF, with rsp_valid exactly 2 cycles after each acceptance.
REQ-038 Alignment, DM_LOAD_ALIGN_EN defined, word 0x10 = 0xDEADBEEF:
- LB 0x13 -> 0xFFFFFFDE;
- LBU 0x13 -> 0x000000DE;
- LH 0x12 -> 0xFFFFDEAD;
- LHU 0x10 -> 0x0000BEEF.
Without the macro, LB 0x13 -> 0xDEADBEEF.
REQ-039 Byte store: word 0x20 = 0x11223344; store bweb=0xFF00FFFF, wdata=0x00AA0000 -> word reads 0x11AA3344.
REQ-040 Out of range, DEPTH_WORDS=1024: store to 0x1000 -> rsp_err=1, rdata=0, no array bit changes. Next request to 0x0 -> rsp_err=0.
REQ-041 WAIT_CYCLES=0 with req_valid held high for three requests -> accepts exactly every 2 cycles, req_ready=0 in RESP, and three rsp_valid pulses.
